// File: rtl/pipe_delay_line_if.sv
// ----------------------------------------------------------------------------
// pipe_delay_line_if
//   Valid/ready/data handshake bundle used on both sides of pipe_delay_line.
//   master : drives valid and data, samples ready (producer side)
//   slave  : samples valid and data, drives ready (consumer side)
// Signals
//   valid  beat present on data
//   ready  consumer accepts the beat this cycle
//   data   payload, WIDTH bits
// ----------------------------------------------------------------------------
interface pipe_delay_line_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_delay_line.sv
// ----------------------------------------------------------------------------
// pipe_delay_line
//   DEPTH-stage pipeline register with valid/ready flow control. Each stage
//   holds a valid bit; empty stages accept data even while downstream is
//   stalled, so bubbles collapse. Unstalled, a beat takes DEPTH edges from
//   input to output. A synchronous flush drops every in-flight beat.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous discard of all stages (blocks both transfers)
//   in_if      upstream handshake (slave): valid/data in, ready out
//   out_if     downstream handshake (master): valid/data out, ready in
//   occupancy  number of valid stages, 0..DEPTH
// ----------------------------------------------------------------------------
module pipe_delay_line #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    pipe_delay_line_if.slave         in_if,
    pipe_delay_line_if.master        out_if,
    output logic [OCC_W-1:0]         occupancy
);

    logic [DEPTH-1:0] v;              // stage valid bits, stage 0 nearest input
    logic [WIDTH-1:0] d    [DEPTH];   // stage data
    logic [DEPTH-1:0] rdy;            // stage k may load this cycle
    logic [DEPTH-1:0] up_v;           // valid presented to stage k
    logic [WIDTH-1:0] up_d [DEPTH];   // data presented to stage k
    logic             chain;
    logic             in_xfer;
    logic             out_xfer;

    // Stage k can load when downstream accepts or any stage from k to the
    // output is empty. This is the ready chain rdy[k] = !v[k] | rdy[k+1]
    // written out per stage, so no signal feeds back into itself.
    always_comb begin
        // NOTE: defaults first so no path through the loop can infer a latch.
        rdy   = '0;
        chain = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            chain = out_if.ready;
            for (int j = k; j < DEPTH; j++) begin
                chain = chain | ~v[j];
            end
            rdy[k] = chain;
        end
    end

    always_comb begin
        up_v[0] = in_if.valid;
        up_d[0] = in_if.data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    assign in_if.ready  = rdy[0] & ~flush;
    assign out_if.valid = v[DEPTH-1] & ~flush;
    assign out_if.data  = d[DEPTH-1];

    assign in_xfer  = in_if.valid  & in_if.ready;
    assign out_xfer = out_if.valid & out_if.ready;

    // NOTE: state updates use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value and the shift happens in one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            // NOTE: the data registers are reset too, because out_data must
            // read RESET_VAL straight out of reset rather than an unknown.
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
        end else if (flush) begin
            // Drop every beat; data registers keep their contents.
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    // A bubble moving in leaves the old data in place.
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// ----------------------------------------------------------------------------
// tb_pipe_delay_line
//   Four instances with DEPTH = 1..4 share clock and reset. A stimulus process
//   drives each instance and pushes accepted beats into a per-instance queue;
//   a monitor on the falling edge pops and compares every output beat, and
//   checks occupancy, in_ready, out_valid and stall stability against a
//   queue/count model.
// ----------------------------------------------------------------------------
module tb_pipe_delay_line;

    localparam int          WIDTH       = 32;
    localparam int          NI          = 4;
    localparam logic [31:0] RST_VAL     = 32'hDEAD_BEEF;
    localparam int          RAND_CYCLES = 10000;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] iv, ordy, fl;
    logic [NI-1:0] ir, ov;
    logic [31:0]   idat [NI];
    logic [31:0]   odat [NI];
    logic [2:0]    occ  [NI];
    int            pc   [NI];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g
        pipe_delay_line_if #(.WIDTH(WIDTH)) ui ();
        pipe_delay_line_if #(.WIDTH(WIDTH)) di ();
        logic [$clog2(gi + 2)-1:0] o;

        assign ui.valid = iv[gi];
        assign ui.data  = idat[gi];
        assign ir[gi]   = ui.ready;
        assign di.ready = ordy[gi];
        assign ov[gi]   = di.valid;
        assign odat[gi] = di.data;

        pipe_delay_line #(
            .WIDTH     (WIDTH),
            .DEPTH     (gi + 1),
            .RESET_VAL (RST_VAL)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (fl[gi]),
            .in_if     (ui),
            .out_if    (di),
            .occupancy (o)
        );

        assign occ[gi] = 3'(o);
        assign pc[gi]  = $countones(u_dut.v);
    end

    beat_t         exp_q [NI][$];
    int            m_occ [NI];
    int            n_out [NI];
    logic [NI-1:0] strm;
    logic [NI-1:0] prev_stall;
    logic [31:0]   prev_dat [NI];
    logic [NI-1:0] nv, nr, nf;
    logic [31:0]   nd [NI];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: apply the pending inputs of every instance, let the
    // combinational ready settle, then record accepted beats.
    task automatic step();
        @(posedge clk);
        #1;
        iv   = nv;
        ordy = nr;
        fl   = nf;
        for (int i = 0; i < NI; i++) idat[i] = nd[i];
        #1;
        for (int i = 0; i < NI; i++) begin
            if (fl[i]) exp_q[i].delete();
            else if (iv[i] && ir[i]) exp_q[i].push_back('{data: idat[i], cyc: cyc});
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] dat,
                         input logic r, input logic f, output logic acc);
        nv[i] = v;
        nd[i] = dat;
        nr[i] = r;
        nf[i] = f;
        step();
        acc = iv[i] & ir[i];
    endtask

    // Monitor: compares against the model state left by the previous edge,
    // then advances the model by this cycle's transfers.
    always @(negedge clk) begin
        int    dep;
        int    lat;
        beat_t b;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_occ[i]      = 0;
                prev_stall[i] = 1'b0;
            end else begin
                dep = i + 1;
                check("occupancy", 32'(occ[i]), 32'(m_occ[i]));
                check("popcount_v", 32'(pc[i]), 32'(m_occ[i]));
                check("in_ready", 32'(ir[i]), 32'(!fl[i] && (m_occ[i] < dep || ordy[i])));
                if (fl[i] || m_occ[i] == 0) check("out_valid_low", 32'(ov[i]), 32'd0);
                else if (m_occ[i] == dep)   check("out_valid_full", 32'(ov[i]), 32'd1);
                if (prev_stall[i] && !fl[i]) begin
                    check("stall_valid", 32'(ov[i]), 32'd1);
                    check("stall_data", odat[i], prev_dat[i]);
                end
                if (ov[i] && ordy[i]) begin
                    check("beat_expected", 32'(exp_q[i].size() != 0), 32'd1);
                    if (exp_q[i].size() != 0) begin
                        b   = exp_q[i].pop_front();
                        lat = cyc - b.cyc;
                        check("out_data", odat[i], b.data);
                        if (strm[i]) check("latency", 32'(lat), 32'(dep));
                        else         check("latency_min", 32'(lat >= dep), 32'd1);
                    end
                    n_out[i]++;
                end
                prev_stall[i] = ov[i] & ~ordy[i];
                prev_dat[i]   = odat[i];
                if (fl[i]) m_occ[i] = 0;
                else m_occ[i] = m_occ[i] + int'(iv[i] & ir[i]) - int'(ov[i] & ordy[i]);
            end
        end
    end

    initial begin
        logic acc;
        int   base;
        int   thr;
        iv = '0; ordy = '0; fl = '0;
        nv = '0; nr = '0; nf = '0;
        strm = '0; prev_stall = '0;
        for (int i = 0; i < NI; i++) begin
            idat[i] = '0; nd[i] = '0; n_out[i] = 0; m_occ[i] = 0; prev_dat[i] = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_out_valid", 32'(ov[i]), 32'd0);
            check("rst_occupancy", 32'(occ[i]), 32'd0);
            check("rst_out_data", odat[i], RST_VAL);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) check("rst_in_ready", 32'(ir[i]), 32'd1);

        // Streaming through DEPTH=3: ten back-to-back beats, exact latency.
        strm[2] = 1'b1;
        base = n_out[2];
        for (int k = 1; k <= 10; k++) begin
            drive(2, 1'b1, 32'(k), 1'b1, 1'b0, acc);
            check("stream_accept", 32'(acc), 32'd1);
        end
        repeat (6) drive(2, 1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("stream_count", 32'(n_out[2] - base), 32'd10);
        strm[2] = 1'b0;

        // Back-pressure on DEPTH=2.
        base = n_out[1];
        drive(1, 1'b1, 32'hAA, 1'b0, 1'b0, acc);
        check("bp_accept_aa", 32'(acc), 32'd1);
        drive(1, 1'b1, 32'hBB, 1'b0, 1'b0, acc);
        check("bp_accept_bb", 32'(acc), 32'd1);
        repeat (3) begin
            drive(1, 1'b1, 32'hCC, 1'b0, 1'b0, acc);
            check("bp_reject_cc", 32'(acc), 32'd0);
            check("bp_hold_data", odat[1], 32'hAA);
        end
        drive(1, 1'b1, 32'hCC, 1'b1, 1'b0, acc);
        check("bp_passthrough_cc", 32'(acc), 32'd1);
        repeat (4) drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("bp_count", 32'(n_out[1] - base), 32'd3);

        // Bubble collapse: beat parked in stage 1, stage 0 empty.
        drive(1, 1'b1, 32'h11, 1'b0, 1'b0, acc);
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0, acc);
        drive(1, 1'b1, 32'h22, 1'b0, 1'b0, acc);
        check("bubble_occ_before", 32'(occ[1]), 32'd1);
        check("bubble_accept", 32'(acc), 32'd1);
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0, acc);
        check("bubble_occ_after", 32'(occ[1]), 32'd2);
        repeat (4) drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Flush with a full pipe and a beat offered.
        drive(1, 1'b1, 32'h31, 1'b0, 1'b0, acc);
        drive(1, 1'b1, 32'h32, 1'b0, 1'b0, acc);
        drive(1, 1'b1, 32'h33, 1'b1, 1'b1, acc);
        check("flush_occ_before", 32'(occ[1]), 32'd2);
        check("flush_no_accept", 32'(acc), 32'd0);
        check("flush_out_valid", 32'(ov[1]), 32'd0);
        drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("flush_occ_after", 32'(occ[1]), 32'd0);
        check("flush_out_valid_after", 32'(ov[1]), 32'd0);
        check("flush_data_held", odat[1], 32'h31);
        repeat (4) drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-stream with occupancy 2.
        drive(1, 1'b1, 32'h41, 1'b0, 1'b0, acc);
        drive(1, 1'b1, 32'h42, 1'b0, 1'b0, acc);
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0, acc);
        #1;
        check("mid_occ_before", 32'(occ[1]), 32'd2);
        reset = 1'b1;
        for (int i = 0; i < NI; i++) exp_q[i].delete();
        #1;
        check("mid_rst_out_valid", 32'(ov[1]), 32'd0);
        check("mid_rst_occupancy", 32'(occ[1]), 32'd0);
        check("mid_rst_out_data", odat[1], RST_VAL);
        @(negedge clk);
        #2;
        reset = 1'b0;
        drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("mid_rst_in_ready", 32'(ir[1]), 32'd1);
        repeat (4) drive(1, 1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Random traffic on all depths with varying downstream pressure.
        for (int c = 0; c < RAND_CYCLES; c++) begin
            thr = 1 + (c / 2500);
            for (int i = 0; i < NI; i++) begin
                nv[i] = ($urandom_range(0, 3) != 0);
                nd[i] = $urandom;
                nr[i] = ($urandom_range(0, 4) < thr);
                nf[i] = ($urandom_range(0, 199) == 0);
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            nv[i] = 1'b0; nr[i] = 1'b1; nf[i] = 1'b0;
        end
        repeat (8) step();
        for (int i = 0; i < NI; i++) check("drain_empty", 32'(exp_q[i].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
